// File: rtl/avaliador_ativos_pkg.sv
// Shared definitions for the accelerator's active-node evaluator.
// Holds the FSM encodings, default field widths and small helpers that
// both the slot and the top-level evaluator rely on.
package avaliador_ativos_pkg;

    localparam int AA_ADDR_WIDTH      = 10;
    localparam int AA_DISTANCIA_WIDTH = 6;
    localparam int AA_CUSTO_WIDTH     = 4;
    localparam int AA_NUM_NA          = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_AVALIAR = 2'd1;
    localparam logic [1:0] ST_APROVAR = 2'd2;

    // Width of an index able to address n slots (never narrower than 1 bit).
    function automatic int largura_indice(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avaliador_ativos_slot.sv
// One entry of the active-node table.
// Stores the node fields, reports address matches for the search and
// removal ports, compares a candidate distance against the stored one and
// produces the distance + cheapest-edge sum used to build the threshold.
module aa_slot
    import avaliador_ativos_pkg::*;
#(
    parameter int ADDR_WIDTH      = AA_ADDR_WIDTH,
    parameter int DISTANCIA_WIDTH = AA_DISTANCIA_WIDTH,
    parameter int CUSTO_WIDTH     = AA_CUSTO_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_escrever,
    input  logic                       i_limpar,
    input  logic                       i_carregar_aprov,
    input  logic [ADDR_WIDTH-1:0]      i_endereco,
    input  logic [DISTANCIA_WIDTH-1:0] i_distancia,
    input  logic [ADDR_WIDTH-1:0]      i_anterior,
    input  logic [CUSTO_WIDTH-1:0]     i_menor_vizinho,
    input  logic [ADDR_WIDTH-1:0]      i_endereco_desativar,
    input  logic [DISTANCIA_WIDTH:0]   i_limiar,
    output logic                       o_valido,
    output logic [ADDR_WIDTH-1:0]      o_endereco,
    output logic [DISTANCIA_WIDTH-1:0] o_distancia,
    output logic [ADDR_WIDTH-1:0]      o_anterior,
    output logic                       o_aprovado,
    output logic                       o_casa_busca,
    output logic                       o_casa_desativar,
    output logic                       o_melhor,
    output logic [DISTANCIA_WIDTH:0]   o_soma
);

    localparam int SW = DISTANCIA_WIDTH + 1;

    logic                       r_valido;
    logic [ADDR_WIDTH-1:0]      r_endereco;
    logic [DISTANCIA_WIDTH-1:0] r_distancia;
    logic [ADDR_WIDTH-1:0]      r_anterior;
    logic [CUSTO_WIDTH-1:0]     r_menor_vizinho;
    logic                       r_aprovado;

    // Entry storage: a write always revokes a previous approval, and an
    // approval is only latched while the entry is left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valido        <= 1'b0;
            r_endereco      <= '0;
            r_distancia     <= '0;
            r_anterior      <= '0;
            r_menor_vizinho <= '0;
            r_aprovado      <= 1'b0;
        end else if (i_escrever) begin
            r_valido        <= 1'b1;
            r_endereco      <= i_endereco;
            r_distancia     <= i_distancia;
            r_anterior      <= i_anterior;
            r_menor_vizinho <= i_menor_vizinho;
            r_aprovado      <= 1'b0;
        end else if (i_limpar) begin
            r_valido        <= 1'b0;
            r_aprovado      <= 1'b0;
        end else if (i_carregar_aprov) begin
            r_aprovado      <= r_valido && (SW'(r_distancia) <= i_limiar);
        end
    end

    // Match, compare and sum logic seen by the table controller.
    always_comb begin
        o_casa_busca     = r_valido && (r_endereco == i_endereco);
        o_casa_desativar = r_valido && (r_endereco == i_endereco_desativar);
        o_melhor         = i_distancia < r_distancia;
        o_soma           = SW'(r_distancia) + SW'(r_menor_vizinho);
    end

    assign o_valido    = r_valido;
    assign o_endereco  = r_endereco;
    assign o_distancia = r_distancia;
    assign o_anterior  = r_anterior;
    assign o_aprovado  = r_aprovado;

endmodule

// File: rtl/avaliador_ativos.sv
// Active-node evaluator.
// Keeps a small table of candidate nodes (insert / improve / remove) and,
// on request, scans the table one slot per cycle to find the threshold
// min(distancia + menor_vizinho), then approves every slot whose distance
// does not exceed that threshold.
module avaliador_ativos
    import avaliador_ativos_pkg::*;
#(
    parameter int ADDR_WIDTH      = AA_ADDR_WIDTH,
    parameter int DISTANCIA_WIDTH = AA_DISTANCIA_WIDTH,
    parameter int CUSTO_WIDTH     = AA_CUSTO_WIDTH,
    parameter int NUM_NA          = AA_NUM_NA
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              lvv_atualizar_in,
    input  logic [ADDR_WIDTH-1:0]             lvv_endereco_in,
    input  logic [DISTANCIA_WIDTH-1:0]        lvv_distancia_in,
    input  logic [ADDR_WIDTH-1:0]             lvv_anterior_in,
    input  logic [CUSTO_WIDTH-1:0]            lvv_menor_vizinho_in,
    input  logic                              lvv_desativar_in,
    input  logic [ADDR_WIDTH-1:0]             lvv_desativar_addr_in,
    input  logic                              cme_avaliar_in,
    output logic                              aa_ocupado_out,
    output logic                              aa_pronto_out,
    output logic [NUM_NA-1:0]                 aa_aprovado_out,
    output logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_out,
    output logic [ADDR_WIDTH*NUM_NA-1:0]      aa_anterior_out,
    output logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_out,
    output logic                              aa_vazio_out,
    output logic                              aa_overflow_out
);

    localparam int SW    = DISTANCIA_WIDTH + 1;
    localparam int IDX_W = largura_indice(NUM_NA);

    logic [1:0]       r_estado;
    logic [IDX_W-1:0] r_idx;
    logic [SW-1:0]    r_limiar;
    logic             r_pronto;
    logic             r_overflow;

    logic w_ocioso;
    logic w_atualizar;
    logic w_desativar;
    logic w_mesmo_end;
    logic w_alguma_casa;
    logic w_cheio;
    logic w_overflow_set;
    logic w_carregar_aprov;
    logic w_sel_valido;
    logic [SW-1:0] w_sel_soma;

    logic [NUM_NA-1:0] w_valido;
    logic [NUM_NA-1:0] w_casa_busca;
    logic [NUM_NA-1:0] w_casa_desat;
    logic [NUM_NA-1:0] w_melhor;
    logic [NUM_NA-1:0] w_livre_primeiro;
    logic [NUM_NA-1:0] w_escrever;
    logic [NUM_NA-1:0] w_limpar;
    logic [NUM_NA-1:0] w_aprovado;

    logic [ADDR_WIDTH-1:0]      w_endereco  [NUM_NA];
    logic [ADDR_WIDTH-1:0]      w_anterior  [NUM_NA];
    logic [DISTANCIA_WIDTH-1:0] w_distancia [NUM_NA];
    logic [SW-1:0]              w_soma      [NUM_NA];

    // Table pulses are honoured only while idle, and an evaluation request
    // in the same cycle takes precedence over them.
    always_comb begin
        w_ocioso         = (r_estado == ST_IDLE);
        w_atualizar      = w_ocioso && lvv_atualizar_in && !cme_avaliar_in;
        w_desativar      = w_ocioso && lvv_desativar_in && !cme_avaliar_in;
        w_mesmo_end      = w_atualizar && w_desativar &&
                           (lvv_endereco_in == lvv_desativar_addr_in);
        w_alguma_casa    = |w_casa_busca;
        w_cheio          = &w_valido;
        w_overflow_set   = w_atualizar && !w_alguma_casa && w_cheio;
        w_carregar_aprov = (r_estado == ST_APROVAR);
    end

    // Lowest-index free slot, one-hot; the insert target when nothing matches.
    always_comb begin
        logic v_achou;
        w_livre_primeiro = '0;
        v_achou          = 1'b0;
        for (int i = 0; i < NUM_NA; i++) begin
            if (!w_valido[i] && !v_achou) begin
                w_livre_primeiro[i] = 1'b1;
                v_achou             = 1'b1;
            end
        end
    end

    // Per-slot write/clear. A removal of the same address as the update is
    // dropped and the update lands unconditionally, so the slot stays valid
    // carrying the new data.
    always_comb begin
        w_escrever = '0;
        w_limpar   = '0;
        for (int i = 0; i < NUM_NA; i++) begin
            w_escrever[i] = w_atualizar &&
                            ((w_casa_busca[i] && (w_melhor[i] || w_mesmo_end)) ||
                             (!w_alguma_casa && w_livre_primeiro[i]));
            w_limpar[i]   = w_desativar && w_casa_desat[i] && !w_mesmo_end;
        end
    end

    for (genvar g = 0; g < NUM_NA; g++) begin : g_slot
        aa_slot #(
            .ADDR_WIDTH      (ADDR_WIDTH),
            .DISTANCIA_WIDTH (DISTANCIA_WIDTH),
            .CUSTO_WIDTH     (CUSTO_WIDTH)
        ) u_slot (
            .clk                  (clk),
            .rst                  (rst),
            .i_escrever           (w_escrever[g]),
            .i_limpar             (w_limpar[g]),
            .i_carregar_aprov     (w_carregar_aprov),
            .i_endereco           (lvv_endereco_in),
            .i_distancia          (lvv_distancia_in),
            .i_anterior           (lvv_anterior_in),
            .i_menor_vizinho      (lvv_menor_vizinho_in),
            .i_endereco_desativar (lvv_desativar_addr_in),
            .i_limiar             (r_limiar),
            .o_valido             (w_valido[g]),
            .o_endereco           (w_endereco[g]),
            .o_distancia          (w_distancia[g]),
            .o_anterior           (w_anterior[g]),
            .o_aprovado           (w_aprovado[g]),
            .o_casa_busca         (w_casa_busca[g]),
            .o_casa_desativar     (w_casa_desat[g]),
            .o_melhor             (w_melhor[g]),
            .o_soma               (w_soma[g])
        );

        assign aa_endereco_out[ADDR_WIDTH*g +: ADDR_WIDTH]           = w_endereco[g];
        assign aa_anterior_out[ADDR_WIDTH*g +: ADDR_WIDTH]           = w_anterior[g];
        assign aa_distancia_out[DISTANCIA_WIDTH*g +: DISTANCIA_WIDTH] = w_distancia[g];
    end

    // Slot currently visited by the scan.
    always_comb begin
        w_sel_valido = 1'b0;
        w_sel_soma   = '0;
        for (int i = 0; i < NUM_NA; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_valido = w_valido[i];
                w_sel_soma   = w_soma[i];
            end
        end
    end

    // Evaluation FSM: start, one-slot-per-cycle threshold scan, approve.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado   <= ST_IDLE;
            r_idx      <= '0;
            r_limiar   <= '1;
            r_pronto   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end
            case (r_estado)
                ST_IDLE: begin
                    if (cme_avaliar_in) begin
                        r_estado <= ST_AVALIAR;
                        r_idx    <= '0;
                        r_limiar <= '1;
                    end
                end
                ST_AVALIAR: begin
                    if (w_sel_valido && (w_sel_soma < r_limiar)) begin
                        r_limiar <= w_sel_soma;
                    end
                    if (r_idx == IDX_W'(NUM_NA - 1)) begin
                        r_estado <= ST_APROVAR;
                        r_idx    <= '0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_APROVAR: begin
                    r_estado <= ST_IDLE;
                    r_pronto <= 1'b1;
                end
                default: begin
                    r_estado <= ST_IDLE;
                end
            endcase
        end
    end

    assign aa_ocupado_out  = (r_estado != ST_IDLE);
    assign aa_pronto_out   = r_pronto;
    assign aa_aprovado_out = w_aprovado;
    assign aa_vazio_out    = ~|w_valido;
    assign aa_overflow_out = r_overflow;

endmodule
